// File: rtl/life_step_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : life_step_engine_pkg
//  Brief    : Shared grid geometry, seed patterns, FSM encoding and helpers
//             for the Game-of-Life step engine.
//  Revision : 1.0
// ============================================================================
package life_step_engine_pkg;

    localparam int GRID_N = 32;
    localparam int CELLS  = GRID_N * GRID_N;
    localparam int ROW_W  = $clog2(GRID_N);
    localparam int RPOP_W = $clog2(GRID_N) + 1;

    localparam logic [CELLS-1:0] C_ONE = {{(CELLS-1){1'b0}}, 1'b1};

    // Cell (r,c) lives at bit r*GRID_N+c.
    localparam logic [CELLS-1:0] PAT_EMPTY   = '0;
    localparam logic [CELLS-1:0] PAT_GLIDER  = (C_ONE << (0*GRID_N + 1))  | (C_ONE << (1*GRID_N + 2))
                                             | (C_ONE << (2*GRID_N + 0))  | (C_ONE << (2*GRID_N + 1))
                                             | (C_ONE << (2*GRID_N + 2));
    localparam logic [CELLS-1:0] PAT_BLINKER = (C_ONE << (15*GRID_N + 14)) | (C_ONE << (15*GRID_N + 15))
                                             | (C_ONE << (15*GRID_N + 16));
    localparam logic [CELLS-1:0] PAT_BLOCK   = (C_ONE << (15*GRID_N + 15)) | (C_ONE << (15*GRID_N + 16))
                                             | (C_ONE << (16*GRID_N + 15)) | (C_ONE << (16*GRID_N + 16));

    localparam int POP_EMPTY   = 0;
    localparam int POP_GLIDER  = 5;
    localparam int POP_BLINKER = 3;
    localparam int POP_BLOCK   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [CELLS-1:0] pattern_of(input logic [1:0] sel);
        case (sel)
            2'd1:    return PAT_GLIDER;
            2'd2:    return PAT_BLINKER;
            2'd3:    return PAT_BLOCK;
            default: return PAT_EMPTY;
        endcase
    endfunction

    function automatic int pattern_pop(input logic [1:0] sel);
        case (sel)
            2'd1:    return POP_GLIDER;
            2'd2:    return POP_BLINKER;
            2'd3:    return POP_BLOCK;
            default: return POP_EMPTY;
        endcase
    endfunction

    function automatic logic [RPOP_W-1:0] row_popcount(input logic [GRID_N-1:0] row);
        logic [RPOP_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < GRID_N; i++) begin
            sum = sum + {{(RPOP_W-1){1'b0}}, row[i]};
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_row_calc.sv
`default_nettype none
// ============================================================================
//  Module   : life_row_calc
//  Brief    : Combinational next-generation row from three adjacent rows.
//             LIFE_TORUS_EN wraps columns; otherwise off-grid cells are dead.
//  Revision : 1.0
// ============================================================================
module life_row_calc
    import life_step_engine_pkg::*;
(
    input  logic [GRID_N-1:0] i_row_above,
    input  logic [GRID_N-1:0] i_row_cur,
    input  logic [GRID_N-1:0] i_row_below,
    output logic [GRID_N-1:0] o_row_next
);

    // Padded rows: bit 0 is column -1, bit GRID_N+1 is column GRID_N.
    logic [GRID_N+1:0] w_above_x;
    logic [GRID_N+1:0] w_cur_x;
    logic [GRID_N+1:0] w_below_x;

`ifdef LIFE_TORUS_EN
    assign w_above_x = {i_row_above[0], i_row_above, i_row_above[GRID_N-1]};
    assign w_cur_x   = {i_row_cur[0],   i_row_cur,   i_row_cur[GRID_N-1]};
    assign w_below_x = {i_row_below[0], i_row_below, i_row_below[GRID_N-1]};
`else
    assign w_above_x = {1'b0, i_row_above, 1'b0};
    assign w_cur_x   = {1'b0, i_row_cur,   1'b0};
    assign w_below_x = {1'b0, i_row_below, 1'b0};
`endif

    generate
        for (genvar c = 0; c < GRID_N; c++) begin : g_col
            logic [3:0] w_cnt;
            assign w_cnt = {3'b000, w_above_x[c]} + {3'b000, w_above_x[c+1]} + {3'b000, w_above_x[c+2]}
                         + {3'b000, w_cur_x[c]}                               + {3'b000, w_cur_x[c+2]}
                         + {3'b000, w_below_x[c]} + {3'b000, w_below_x[c+1]} + {3'b000, w_below_x[c+2]};
            assign o_row_next[c] = (w_cnt == 4'd3) || (w_cur_x[c+1] && (w_cnt == 4'd2));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/life_step_engine.sv
`default_nettype none
// ============================================================================
//  Module   : life_step_engine
//  Brief    : Handshaked Game-of-Life engine, one row per clock into a shadow
//             buffer, committed atomically. LIFE_TORUS_EN selects wrapped edges.
//  Revision : 1.0
// ============================================================================
module life_step_engine
    import life_step_engine_pkg::*;
#(
    parameter int GEN_W = 16,
    parameter int POP_W = 11
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         init_sel,
    input  logic               load,
    input  logic               step_req,
    output logic               busy,
    output logic               done,
    output logic [CELLS-1:0]   grid_pack,
    output logic [GEN_W-1:0]   gen_count,
    output logic [POP_W-1:0]   population
);

    localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(GRID_N - 1);
    localparam logic [ROW_W-1:0] C_ROW_ONE  = ROW_W'(1);
    localparam logic [GEN_W-1:0] C_GEN_ONE  = GEN_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_start;
    logic [ROW_W-1:0]   r_row;
    logic [ROW_W-1:0]   w_row_up;
    logic [ROW_W-1:0]   w_row_dn;
    logic [2*ROW_W-1:0] w_base_up;
    logic [2*ROW_W-1:0] w_base_cur;
    logic [2*ROW_W-1:0] w_base_dn;
    logic [CELLS-1:0]   r_grid;
    logic [CELLS-1:0]   r_shadow;
    logic [POP_W-1:0]   r_pop_acc;
    logic [POP_W-1:0]   r_population;
    logic [GEN_W-1:0]   r_gen;
    logic               r_done;
    logic [GRID_N-1:0]  w_row_above;
    logic [GRID_N-1:0]  w_row_cur;
    logic [GRID_N-1:0]  w_row_below;
    logic [GRID_N-1:0]  w_row_next;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!load && step_req) begin
                    w_state_next = ST_RUN;
                    w_start      = 1'b1;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_row == C_LAST_ROW) w_state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                busy         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Row index arithmetic wraps modulo GRID_N, which is the torus neighbourhood.
    assign w_row_up   = r_row - C_ROW_ONE;
    assign w_row_dn   = r_row + C_ROW_ONE;
    assign w_base_up  = {w_row_up, {ROW_W{1'b0}}};
    assign w_base_cur = {r_row,    {ROW_W{1'b0}}};
    assign w_base_dn  = {w_row_dn, {ROW_W{1'b0}}};
    assign w_row_cur  = r_grid[w_base_cur +: GRID_N];

`ifdef LIFE_TORUS_EN
    assign w_row_above = r_grid[w_base_up +: GRID_N];
    assign w_row_below = r_grid[w_base_dn +: GRID_N];
`else
    assign w_row_above = (r_row == '0)         ? '0 : r_grid[w_base_up +: GRID_N];
    assign w_row_below = (r_row == C_LAST_ROW) ? '0 : r_grid[w_base_dn +: GRID_N];
`endif

    life_row_calc u_row_calc (
        .i_row_above (w_row_above),
        .i_row_cur   (w_row_cur),
        .i_row_below (w_row_below),
        .o_row_next  (w_row_next)
    );

    // The shadow buffer needs no reset: every row is rewritten before a commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grid       <= pattern_of(init_sel);
            r_population <= POP_W'(pattern_pop(init_sel));
            r_gen        <= '0;
            r_row        <= '0;
            r_pop_acc    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_grid       <= pattern_of(init_sel);
                        r_population <= POP_W'(pattern_pop(init_sel));
                        r_gen        <= '0;
                    end else if (w_start) begin
                        r_row     <= '0;
                        r_pop_acc <= '0;
                    end
                end
                ST_RUN: begin
                    r_shadow[w_base_cur +: GRID_N] <= w_row_next;
                    r_pop_acc <= r_pop_acc + POP_W'(row_popcount(w_row_next));
                    r_row     <= r_row + C_ROW_ONE;
                end
                ST_COMMIT: begin
                    r_grid       <= r_shadow;
                    r_population <= r_pop_acc;
                    r_gen        <= r_gen + C_GEN_ONE;
                    r_done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done       = r_done;
    assign grid_pack  = r_grid;
    assign gen_count  = r_gen;
    assign population = r_population;

endmodule
`default_nettype wire

// File: doc/life_step_engine.md
Name: life_step_engine

Overview:
- Game-of-Life generation engine for a 32x32 grid; feeds the packed 1024-bit grid consumed by the VGA pixel stage.
- Replaces the free-running update with a step handshake:
  - one generation computed per accepted request;
  - one row per clock;
  - double-buffered, so the displayed grid never tears mid-step.
- Also reports the generation count and live-cell population.

Parameters:
- GRID_N, 32, rows = columns; grid_pack width is GRID_N*GRID_N.
- GEN_W, 16, generation counter width.
- POP_W, 11, population counter width; must hold GRID_N*GRID_N.

Ports:
- clk  in  1  engine clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- init_sel  in  2  initial pattern select, sampled on reset or load.
- load  in  1  reload the pattern from init_sel (honoured only in IDLE).
- step_req  in  1  request one generation (honoured only in IDLE).
- busy  out  1  high while a generation is in progress.
- done  out  1  single-cycle pulse when a new grid is committed.
- grid_pack  out  1024  display buffer; cell (r,c) is bit r*GRID_N+c; row 0 is top, column 0 is left.
- gen_count  out  GEN_W  generations since the last reset/load; wraps from 0xFFFF to 0.
- population  out  POP_W  live cells in grid_pack.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, gen_count=0, grid_pack=pattern(init_sel), population=count of that pattern.
- Reset mid-step aborts the step; the shadow buffer is discarded.
- Patterns:
  - 0: empty, population 0.
  - 1: glider at (0,1),(1,2),(2,0),(2,1),(2,2), population 5.
  - 2: horizontal blinker at (15,14),(15,15),(15,16), population 3.
  - 3: 2x2 block at (15,15),(15,16),(16,15),(16,16), population 4.
- States: IDLE, RUN, COMMIT.
- IDLE:
  - load=1 reloads the pattern, clears gen_count and sets population, with no busy and no done.
  - load wins over a simultaneous step_req.
  - Otherwise step_req=1 moves to RUN with row=0, pop_acc=0, busy=1 from the next cycle.
- RUN, one cycle per row r = 0..31:
  - shadow[r] = next-state row computed from grid rows r-1, r and r+1. Reads come from grid_pack, which is unchanged during RUN.
  - pop_acc += popcount(shadow[r]).
  - After r=31, go to COMMIT.
- Cell rule: the next state is live if neighbours=3, or if the cell is live and neighbours=2; otherwise dead. The neighbour count is 0..8 (4 bits).
- COMMIT, one cycle:
  - grid_pack=shadow, population=pop_acc, gen_count+=1, done=1 for this cycle only.
  - busy=0 from the next cycle; return to IDLE.
- Latency: step_req sampled high at edge E0 → busy high after E0 → grid_pack, gen_count, population and done updated after E33.
- Step period is 34 cycles including the mandatory IDLE cycle.
- step_req or load while busy: ignored, not queued.
- step_req held high: back-to-back generations, one IDLE cycle between them.
- init_sel changes outside reset/load have no effect.

Optional Feature:
- Macro: LIFE_TORUS_EN.
- Defined: toroidal edges.
  - Row -1 maps to row 31 and row 32 to row 0.
  - Column -1 maps to column 31 and column 32 to column 0.
- Undefined: cells outside the grid read as dead. An edge blinker still oscillates; a glider dies into a block at the corner.

Decomposition:
- Shared package/include holds:
  - GRID_N;
  - pattern constants PAT_EMPTY, PAT_GLIDER, PAT_BLINKER, PAT_BLOCK (1024-bit literals);
  - their populations;
  - state encodings.
- One sub-module, life_row_calc: combinational; inputs are the above, current and below rows (32 bits each); output is the next row (32 bits). Edge handling inside it is selected by LIFE_TORUS_EN.
- The engine holds the FSM, row counter, shadow buffer, population accumulator and generation counter.

Test Plan:
- rst with init_sel=2, then step_req pulse → after 34 cycles the blinker is vertical at (14,15),(15,15),(16,15); population=3, gen_count=1, done high exactly 1 cycle. A second step restores the horizontal blinker, gen_count=2.
- init_sel=3 block, 10 steps → grid_pack unchanged every commit; population=4, gen_count=10.
- init_sel=1 glider, 4 steps → glider shifted by +1 row and +1 column, i.e. (1,2),(2,3),(3,1),(3,2),(3,3); population=5.
- Glider run past the bottom-right corner (~124 steps):
  - with LIFE_TORUS_EN → reappears at the top-left, population=5;
  - without it → settles to a 2x2 block, population=4.
- step_req and load re-asserted during busy → ignored; commit at the original cycle; gen_count increments once. load and step_req together in IDLE → pattern reloaded, gen_count=0, no busy.
- rst asserted at row 17 of a RUN → next cycle IDLE, busy=0, grid=pattern(init_sel), no done pulse; step_req held high for 200 cycles → exactly 5 done pulses (34-cycle period, counting from the first edge).
